// File: rtl/apb_gen_pkg.sv
// Shared definitions for the generic APB3 master.
// Contents: the state encoding, and integer helpers that size the slave-index
// field and the timeout counter.
package apb_gen_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS
  } apb_state_e;

  // Smallest r such that (1 << r) >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Width of the slave-index field. A single slave still gets one bit.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Width of a counter that can hold the value t (at least one bit).
  function automatic int tmo_w(input int t);
    return (clog2(t + 1) < 1) ? 1 : clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Address-to-slave decoder for the APB master.
// Ports:
//   addr     in   ADDR_W   transfer address
//   idx      out  SEL_W    slave index taken from the top address bits
//   dec_err  out  1        index does not name an existing slave
// Purely combinational.
module apb_addr_decoder
  import apb_gen_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = sel_w(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  idx,
  output logic              dec_err
);

  generate
    if (NUM_SLAVES == 1) begin : g_single
      // With one slave every address maps to it; the address is not decoded.
      logic unused_addr;
      assign unused_addr = ^addr;
      assign idx         = '0;
      assign dec_err     = 1'b0;
    end else begin : g_multi
      assign idx     = addr[ADDR_W-1 -: SEL_W];
      // Only reachable when NUM_SLAVES is not a power of two.
      assign dec_err = (int'(idx) >= NUM_SLAVES);
    end
  endgenerate

endmodule

// File: rtl/apb_master_nslave.sv
// Parametrised APB3 master. Accepts one read/write request at a time on a
// valid/ready port and runs a single APB transfer (SETUP, ACCESS, wait states)
// to one of NUM_SLAVES slaves, then emits a one-cycle response pulse.
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   req_valid/req_ready               request handshake (ready == IDLE)
//   req_write, req_addr, req_wdata    request payload
//   rsp_valid, rsp_rdata, rsp_err     completion pulse, read data, error
//   paddr, psel, penable, pwrite,
//   pwdata                            APB master outputs (registered)
//   prdata_bus, pready_bus,
//   pslverr_bus                       per-slave APB returns
module apb_master_nslave
  import apb_gen_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_SLAVES  = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [ADDR_W-1:0]            paddr,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata_bus,
  input  logic [NUM_SLAVES-1:0]        pready_bus,
  input  logic [NUM_SLAVES-1:0]        pslverr_bus
);

  localparam int SEL_W = sel_w(NUM_SLAVES);
  localparam int TMO_W = tmo_w(TIMEOUT_CYC);

  apb_state_e              state_q, state_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [TMO_W-1:0]        cnt_q, cnt_d;
  logic                    dec_err_q, dec_err_d;

  logic [SEL_W-1:0]        dec_idx;
  logic                    dec_err;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    sel_ready, sel_err;
  logic [DATA_W-1:0]       sel_rdata;
  logic [TMO_W-1:0]        cnt_inc;
  logic                    timeout;

  apb_addr_decoder #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_dec (
    .addr    (req_addr),
    .idx     (dec_idx),
    .dec_err (dec_err)
  );

  // One-hot select for the decoded slave; all-zero on a decode error.
  always_comb begin
    dec_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      dec_onehot[k] = !dec_err && (int'(dec_idx) == k);
  end

  // The registered psel is the one-hot selector for the slave return mux.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (psel_q[k]) begin
        sel_ready = pready_bus[k];
        sel_err   = pslverr_bus[k];
        sel_rdata = prdata_bus[k*DATA_W +: DATA_W];
      end
    end
  end

  // Timeout fires on the ACCESS cycle where the low-PREADY count reaches
  // TIMEOUT_CYC; PREADY in that same cycle takes priority.
  assign cnt_inc = cnt_q + TMO_W'(1);
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_inc == TMO_W'(TIMEOUT_CYC));

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    dec_err_d   = dec_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d   = req_addr;
          pwdata_d  = req_wdata;
          pwrite_d  = req_write;
          psel_d    = dec_onehot;
          dec_err_d = dec_err;
          cnt_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (dec_err_q) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          penable_d = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else if (timeout) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      dec_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      dec_err_q   <= dec_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Bench for apb_master_nslave with 3 slaves (so address 0xC0.. is a decode
// error) and a 4-cycle PREADY timeout. Slaves are modelled as per-cycle
// stimulus: the addressed slave raises PREADY in a chosen ACCESS cycle while
// unaddressed slaves and non-ready cycles carry random noise.
module tb_apb_master_nslave;

  localparam int NS  = 3;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_write;
  logic [7:0]    req_addr, req_wdata;
  logic          rsp_valid, rsp_err;
  logic [7:0]    rsp_rdata, paddr, pwdata;
  logic [NS-1:0] psel;
  logic          penable, pwrite;
  logic [NS*8-1:0] prdata_bus;
  logic [NS-1:0] pready_bus, pslverr_bus;

  always #5 clk = ~clk;

  apb_master_nslave #(
    .ADDR_W(8), .DATA_W(8), .NUM_SLAVES(NS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata_bus(prdata_bus), .pready_bus(pready_bus), .pslverr_bus(pslverr_bus)
  );

  // One transfer: stimulus plus expected response (lat = cycles from accept
  // edge to the cycle where rsp_valid is seen; waits >= TMO means PREADY never comes).
  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [3:0] waits;
    logic       slverr;
    logic [3:0] lat;
    logic       err;
    logic [7:0] rd;
    logic [2:0] ps;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic       last_err;
  logic [7:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [7:0] rdata, input int waits, input logic slverr,
                              input int lat, input logic err, input logic [7:0] rd,
                              input logic [2:0] ps);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = 4'(waits);
    v.slverr = slverr; v.lat = 4'(lat); v.err = err; v.rd = rd; v.ps = ps;
    return v;
  endfunction

  // Reference: slave number is the address divided by the 64-byte window size.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   slave;
    r = v;
    slave = int'(v.addr) / 64;
    if (slave >= NS) begin
      r.lat = 4'd2; r.err = 1'b1; r.rd = 8'h00; r.ps = 3'b000;
    end else begin
      r.ps = 3'(1 << slave);
      if (int'(v.waits) >= TMO) begin
        r.lat = 4'(2 + TMO); r.err = 1'b1; r.rd = 8'h00;
      end else begin
        r.lat = 4'(3 + int'(v.waits));
        r.err = v.slverr;
        r.rd  = (v.wr || v.slverr) ? 8'h00 : v.rdata;
      end
    end
    return r;
  endfunction

  // Drive slave returns for cycle c after accept (c=1 is SETUP).
  task automatic drive_slaves(input vec_t v, input int c);
    int slave;
    for (int k = 0; k < NS; k++) begin
      pready_bus[k]        = 1'($urandom);
      pslverr_bus[k]       = 1'($urandom);
      prdata_bus[k*8 +: 8] = 8'($urandom);
    end
    slave = int'(v.addr) / 64;
    if (slave < NS) begin
      pready_bus[slave] = (int'(v.waits) < TMO) && (c == 2 + int'(v.waits));
      if (pready_bus[slave]) begin
        pslverr_bus[slave]       = v.slverr;
        prdata_bus[slave*8 +: 8] = v.rdata;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present the request in the current cycle; returns in the rsp_valid cycle,
  // so a following call issues back-to-back.
  task automatic run_txn(input vec_t v);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    chk("req_ready_idle", req_ready, 1);
    drive_slaves(v, 0);
    step();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    for (int c = 1; c <= int'(v.lat); c++) begin
      if (c < int'(v.lat)) begin
        chk("rsp_valid_early", rsp_valid, 0);
        chk("req_ready_busy", req_ready, 0);
        chk("psel", psel, v.ps);
        chk("penable", penable, (c >= 2) ? 1 : 0);
        chk("paddr_hold", paddr, v.addr);
        chk("pwrite_hold", pwrite, v.wr);
        chk("pwdata_hold", pwdata, v.wdata);
        drive_slaves(v, c);
        step();
      end else begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, v.err);
        chk("rsp_rdata", rsp_rdata, v.rd);
        chk("psel_done", psel, 0);
        chk("penable_done", penable, 0);
        chk("req_ready_done", req_ready, 1);
        last_err = v.err;
        last_rd  = v.rd;
      end
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_slaves(mk(0, 8'hFF, 0, 0, 15, 0, 0, 0, 0, 0), 0);
      step();
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_rsp_err_hold", rsp_err, last_err);
      chk("idle_rsp_rdata_hold", rsp_rdata, last_rd);
      chk("idle_psel", psel, 0);
      chk("idle_penable", penable, 0);
      chk("idle_req_ready", req_ready, 1);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    tbl[0] = mk(1, 8'h10, 8'hA5, 8'h00, 0, 0, 3, 0, 8'h00, 3'b001); // write, no waits
    tbl[1] = mk(0, 8'h80, 8'h00, 8'h3C, 3, 0, 6, 0, 8'h3C, 3'b100); // PREADY in 4th ACCESS cycle wins
    tbl[2] = mk(0, 8'h40, 8'h00, 8'h77, 0, 1, 3, 1, 8'h00, 3'b010); // PSLVERR on read
    tbl[3] = mk(0, 8'hC0, 8'h11, 8'h22, 0, 0, 2, 1, 8'h00, 3'b000); // decode error
    tbl[4] = mk(0, 8'h50, 8'h00, 8'h99, 9, 0, 6, 1, 8'h00, 3'b010); // timeout
    tbl[5] = mk(1, 8'h7F, 8'h5E, 8'h00, 1, 1, 4, 1, 8'h00, 3'b010); // write + PSLVERR
    tbl[6] = mk(0, 8'h3F, 8'h00, 8'hE1, 2, 0, 5, 0, 8'hE1, 3'b001); // read, 2 waits
    tbl[7] = mk(1, 8'hFF, 8'h12, 8'h00, 0, 0, 2, 1, 8'h00, 3'b000); // decode error, write
    tbl[8] = mk(0, 8'hBF, 8'h00, 8'h44, 4, 0, 6, 1, 8'h00, 3'b100); // timeout, exactly TMO waits
    tbl[9] = mk(0, 8'h00, 8'h00, 8'h5A, 0, 0, 3, 0, 8'h5A, 3'b001); // read, no waits

    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    prdata_bus = '0; pready_bus = '0; pslverr_bus = '0;
    step(); step();
    chk_reset_state("reset");
    resetn = 1'b1;
    last_err = 1'b0; last_rd = 8'h00;
    idle(1);

    foreach (tbl[i]) begin
      run_txn(tbl[i]);
      if (i % 2 == 1) idle(1);
    end
    idle(2);

    // Reset while in ACCESS with PREADY low: transfer dropped, no response.
    v = mk(0, 8'h40, 8'h00, 8'h00, 15, 0, 0, 0, 0, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
    drive_slaves(v, 0);
    step();
    req_valid = 1'b0;
    drive_slaves(v, 1);
    step();
    chk("mid_penable", penable, 1);
    chk("mid_psel", psel, 3'b010);
    drive_slaves(v, 2);
    resetn = 1'b0;
    step();
    chk_reset_state("midreset");
    resetn = 1'b1;
    last_err = 1'b0; last_rd = 8'h00;
    idle(3);
    run_txn(tbl[9]);
    run_txn(tbl[1]);
    idle(1);

    // Randomized transfers against the reference model.
    for (int n = 0; n < 60; n++) begin
      v.wr     = 1'($urandom);
      v.addr   = 8'($urandom);
      v.wdata  = 8'($urandom);
      v.rdata  = 8'($urandom);
      v.waits  = 4'($urandom_range(0, 6));
      v.slverr = ($urandom_range(0, 3) == 0);
      run_txn(model(v));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
